// File: rtl/burst_tx.sv
// Write-domain burst source: emits LEN words SEED, SEED+1, ... into a FIFO write port,
// holding each word while WFULL is high, and reports count, XOR checksum and a done pulse.
module burst_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 8
) (
    input  logic                  WCLK,
    input  logic                  W_RST,
    input  logic                  START,
    input  logic [CNT_W-1:0]      LEN,
    input  logic [DATA_WIDTH-1:0] SEED,
    input  logic                  WFULL,
    output logic                  W_INC,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [CNT_W-1:0]      SENT_CNT,
    output logic [DATA_WIDTH-1:0] CHECKSUM
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } state_t;

    state_t                state_q;
    logic                  w_inc_q;
    logic                  busy_q;
    logic                  done_q;
    logic [CNT_W-1:0]      len_q;
    logic [CNT_W-1:0]      sent_cnt_q;
    logic [DATA_WIDTH-1:0] seed_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] checksum_q;

    logic [CNT_W-1:0]      sent_cnt_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic                  xfer;

    // A word moves exactly when the FIFO would count it: W_INC high and not full.
    assign xfer       = w_inc_q && !WFULL;
    assign sent_cnt_d = sent_cnt_q + CNT_W'(1);
    assign wdata_d    = seed_q + DATA_WIDTH'(sent_cnt_d);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge WCLK or negedge W_RST) begin
        if (!W_RST) begin
            state_q    <= S_IDLE;
            w_inc_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            len_q      <= '0;
            sent_cnt_q <= '0;
            seed_q     <= '0;
            wdata_q    <= '0;
            checksum_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        len_q      <= LEN;
                        seed_q     <= SEED;
                        sent_cnt_q <= '0;
                        checksum_q <= '0;
                        busy_q     <= 1'b1;
                        if (LEN != '0) begin
                            state_q <= S_SEND;
                            w_inc_q <= 1'b1;
                            wdata_q <= SEED;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_SEND: begin
                    if (xfer) begin
                        sent_cnt_q <= sent_cnt_d;
                        checksum_q <= checksum_q ^ wdata_q;
                        wdata_q    <= wdata_d;
                        if (sent_cnt_d == len_q) begin
                            state_q <= S_DONE;
                            w_inc_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    w_inc_q <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign W_INC    = w_inc_q;
    assign WDATA    = wdata_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign SENT_CNT = sent_cnt_q;
    assign CHECKSUM = checksum_q;

endmodule
